// File: rtl/pc_gen_unit.sv
// Fetch PC generator: next PC by priority redirect > BTB hit > sequential; optional BTB under `PC_BTB_EN`.
// Latency: 1 cycle from redirect (or BTB hit) to current_pc when pc_write=1 and cache_stall=0.
// Backpressure: pc_write=0 or cache_stall=1 holds the PC; a redirect seen while held is parked until release.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              BTB_ENTRIES  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pc_write,
    input  logic            cache_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic [XLEN-1:0] btb_upd_target,
    output logic [XLEN-1:0] current_pc,
    output logic            fetch_valid,
    output logic            pc_advanced,
    output logic            pred_taken,
    output logic            redirect_pending,
    output logic            misalign_err
);

    localparam int              OFF_W      = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << OFF_W;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pend_pc;
    logic            adv;
    logic [XLEN-1:0] redir_aligned;
    logic            redir_mis;
    logic [XLEN-1:0] seq_pc;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;

    assign adv           = pc_write & ~cache_stall;
    assign redir_aligned = redirect_pc & ALIGN_MASK;
    assign redir_mis     = |(redirect_pc & ~ALIGN_MASK);
    // Wraps modulo 2^XLEN by construction.
    assign seq_pc        = current_pc + XLEN'(INSTR_BYTES);

`ifdef PC_BTB_EN
    localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
    localparam int TAG_W = XLEN - OFF_W - IDX_W;

    logic [BTB_ENTRIES-1:0] btb_vld;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
    logic [IDX_W-1:0]       lkp_idx;
    logic [TAG_W-1:0]       lkp_tag;
    logic [IDX_W-1:0]       upd_idx;
    logic [TAG_W-1:0]       upd_tag;
    logic                   unused_upd_lsb;

    assign lkp_idx        = current_pc[OFF_W +: IDX_W];
    assign lkp_tag        = current_pc[XLEN-1 -: TAG_W];
    assign upd_idx        = btb_upd_pc[OFF_W +: IDX_W];
    assign upd_tag        = btb_upd_pc[XLEN-1 -: TAG_W];
    assign unused_upd_lsb = ^btb_upd_pc[OFF_W-1:0];

    // Writes land on the edge; a lookup of the same entry sees them next cycle.
    assign btb_hit    = btb_vld[lkp_idx] && (btb_tag[lkp_idx] == lkp_tag);
    assign btb_target = btb_tgt[lkp_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btb_vld <= '0;
        end else if (btb_upd_valid) begin
            btb_vld[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_upd_valid) begin
            btb_tag[upd_idx] <= upd_tag;
            btb_tgt[upd_idx] <= btb_upd_target;
        end
    end
`else
    logic unused_btb_upd;

    assign unused_btb_upd = ^{btb_upd_valid, btb_upd_pc, btb_upd_target};
    assign btb_hit        = 1'b0;
    assign btb_target     = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_BOOT;
            current_pc       <= RESET_VECTOR;
            pend_pc          <= '0;
            fetch_valid      <= 1'b0;
            pc_advanced      <= 1'b0;
            pred_taken       <= 1'b0;
            redirect_pending <= 1'b0;
            misalign_err     <= 1'b0;
        end else begin
            pc_advanced  <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                ST_BOOT: begin
                    fetch_valid <= 1'b1;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        misalign_err <= redir_mis;
                        if (adv) begin
                            current_pc  <= redir_aligned;
                            pred_taken  <= 1'b0;
                            pc_advanced <= 1'b1;
                        end else begin
                            pend_pc          <= redir_aligned;
                            redirect_pending <= 1'b1;
                            state            <= ST_PEND;
                        end
                    end else if (adv) begin
                        current_pc  <= btb_hit ? btb_target : seq_pc;
                        pred_taken  <= btb_hit;
                        pc_advanced <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (redirect_valid) begin
                        misalign_err <= redir_mis;
                    end
                    // The youngest redirect wins, including one arriving on the release cycle.
                    if (adv) begin
                        current_pc       <= redirect_valid ? redir_aligned : pend_pc;
                        pred_taken       <= 1'b0;
                        pc_advanced      <= 1'b1;
                        redirect_pending <= 1'b0;
                        state            <= ST_RUN;
                    end else if (redirect_valid) begin
                        pend_pc <= redir_aligned;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios then random traffic against a queue/array reference model.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pc_write = 1'b0;
    logic        cache_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        btb_upd_valid = 1'b0;
    logic [31:0] btb_upd_pc = '0;
    logic [31:0] btb_upd_target = '0;
    logic [31:0] current_pc;
    logic        fetch_valid;
    logic        pc_advanced;
    logic        pred_taken;
    logic        redirect_pending;
    logic        misalign_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_boot;
    logic        m_fv, m_adv, m_pred, m_mis;
    logic [31:0] m_pend [$];
    logic [31:0] m_btb_pc  [int];
    logic [31:0] m_btb_tgt [int];

    pc_gen_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_write         (pc_write),
        .cache_stall      (cache_stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .btb_upd_valid    (btb_upd_valid),
        .btb_upd_pc       (btb_upd_pc),
        .btb_upd_target   (btb_upd_target),
        .current_pc       (current_pc),
        .fetch_valid      (fetch_valid),
        .pc_advanced      (pc_advanced),
        .pred_taken       (pred_taken),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   current_pc,       m_pc);
        chk({tag, ".fv"},   fetch_valid,      m_fv);
        chk({tag, ".adv"},  pc_advanced,      m_adv);
        chk({tag, ".pred"}, pred_taken,       m_pred);
        chk({tag, ".pend"}, redirect_pending, m_pend.size() != 0);
        chk({tag, ".mis"},  misalign_err,     m_mis);
    endtask

    function automatic bit btb_lookup(input logic [31:0] pc, output logic [31:0] tgt);
        int idx;
        tgt = '0;
        idx = int'((pc >> 2) % 8);
`ifdef PC_BTB_EN
        if (m_btb_pc.exists(idx) && ((m_btb_pc[idx] >> 5) == (pc >> 5))) begin
            tgt = m_btb_tgt[idx];
            return 1'b1;
        end
`endif
        return (idx < 0);
    endfunction

    task automatic drive(input logic pw, input logic cs, input logic rv, input logic [31:0] rpc);
        pc_write       = pw;
        cache_stall    = cs;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Predict the effect of the coming edge, take it, then compare away from the edge.
    task automatic step(input string tag);
        logic        adv;
        logic [31:0] tgt;
        bit          hit;
        adv   = pc_write && !cache_stall;
        m_adv = 1'b0;
        m_mis = 1'b0;
        hit   = btb_lookup(m_pc, tgt);
        if (m_boot) begin
            m_boot = 1'b0;
            m_fv   = 1'b1;
        end else begin
            if (redirect_valid) m_mis = (redirect_pc[1:0] != 2'b00);
            if (adv) begin
                if (redirect_valid) begin
                    m_pc = {redirect_pc[31:2], 2'b00};
                    m_pred = 1'b0;
                end else if (m_pend.size() != 0) begin
                    m_pc = m_pend[$];
                    m_pred = 1'b0;
                end else begin
                    m_pc   = hit ? tgt : m_pc + 32'd4;
                    m_pred = hit;
                end
                m_pend.delete();
                m_adv = 1'b1;
            end else if (redirect_valid) begin
                m_pend.push_back({redirect_pc[31:2], 2'b00});
            end
        end
        if (btb_upd_valid) begin
            m_btb_pc[int'((btb_upd_pc >> 2) % 8)]  = btb_upd_pc;
            m_btb_tgt[int'((btb_upd_pc >> 2) % 8)] = btb_upd_target;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        drive(1'b0, 1'b0, 1'b0, '0);
        btb_upd_valid = 1'b0;
        reset_n = 1'b0;
        m_pc = 32'h0; m_boot = 1'b1; m_fv = 1'b0; m_adv = 1'b0; m_pred = 1'b0; m_mis = 1'b0;
        m_pend.delete(); m_btb_pc.delete(); m_btb_tgt.delete();
        #1;
        check_all({tag, "_async"});
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check_all(tag);
    endtask

    initial begin
        // 1: reset, boot bubble, sequential
        do_reset("rst");
        drive(1'b1, 1'b0, 1'b0, '0);
        step("boot");
        chk("t1_fv_after_boot", fetch_valid, 1'b1);
        step("seq1");
        chk("t1_pc4", current_pc, 32'h4);
        step("seq2");
        chk("t1_pc8", current_pc, 32'h8);
        step("seq3");
        step("seq4");
        chk("t2_pc10", current_pc, 32'h10);

        // 2: redirect during a 3-cycle cache stall is parked
        drive(1'b1, 1'b1, 1'b0, '0);         step("t2_s1");
        drive(1'b1, 1'b1, 1'b1, 32'h200);    step("t2_s2");
        chk("t2_pending", redirect_pending, 1'b1);
        chk("t2_hold", current_pc, 32'h10);
        drive(1'b1, 1'b1, 1'b0, '0);         step("t2_s3");
        drive(1'b1, 1'b0, 1'b0, '0);         step("t2_rel");
        chk("t2_pc200", current_pc, 32'h200);
        chk("t2_pend0", redirect_pending, 1'b0);

        // 3: youngest of two parked redirects wins
        drive(1'b1, 1'b1, 1'b1, 32'h300);    step("t3_r1");
        drive(1'b1, 1'b1, 1'b1, 32'h400);    step("t3_r2");
        drive(1'b1, 1'b0, 1'b0, '0);         step("t3_rel");
        chk("t3_pc400", current_pc, 32'h400);

        // Hazard hold with a fresh redirect on the release cycle
        drive(1'b0, 1'b0, 1'b1, 32'h600);    step("t3b_park");
        drive(1'b1, 1'b0, 1'b1, 32'h704);    step("t3b_rel");
        chk("t3b_pc704", current_pc, 32'h704);

        // 4: misaligned redirect
        drive(1'b1, 1'b0, 1'b1, 32'h102);    step("t4_mis");
        chk("t4_pc100", current_pc, 32'h100);
        chk("t4_mis1", misalign_err, 1'b1);
        drive(1'b1, 1'b0, 1'b0, '0);         step("t4_after");
        chk("t4_mis0", misalign_err, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h203);    step("t4_park_mis");
        drive(1'b1, 1'b0, 1'b0, '0);         step("t4_park_rel");
        chk("t4_pc200", current_pc, 32'h200);

        // 5: wrap at top of address space
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC); step("t5_top");
        drive(1'b1, 1'b0, 1'b0, '0);            step("t5_wrap");
        chk("t5_pc0", current_pc, 32'h0);

        // Reset while a redirect is parked
        drive(1'b1, 1'b1, 1'b1, 32'h800);    step("pend_park");
        do_reset("rst_pend");
        drive(1'b1, 1'b0, 1'b0, '0);         step("boot2");

        // 6: BTB prediction and redirect override
        btb_upd_valid = 1'b1; btb_upd_pc = 32'h40; btb_upd_target = 32'h80;
        drive(1'b0, 1'b0, 1'b0, '0);         step("t6_upd");
        btb_upd_valid = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h3C);     step("t6_to3c");
        drive(1'b1, 1'b0, 1'b0, '0);         step("t6_at40");
        step("t6_pred");
`ifdef PC_BTB_EN
        chk("t6_pc80", current_pc, 32'h80);
        chk("t6_pred1", pred_taken, 1'b1);
`else
        chk("t6_pc44", current_pc, 32'h44);
        chk("t6_pred0", pred_taken, 1'b0);
`endif
        drive(1'b1, 1'b0, 1'b1, 32'h40);     step("t6_back40");
        drive(1'b1, 1'b0, 1'b1, 32'h500);    step("t6_override");
        chk("t6_pc500", current_pc, 32'h500);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, 32'($urandom_range(0, 255)));
            btb_upd_valid  = $urandom_range(0, 5) == 0;
            btb_upd_pc     = 32'($urandom_range(0, 63)) << 2;
            btb_upd_target = 32'($urandom_range(0, 63)) << 2;
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
